// File: rtl/free_list_pkg.sv
// Sizing shared by the free list and the architectural/speculative map tables.
// All widths derive from the ROB size, so the blocks stay consistent with each other.
`ifndef N_ENTRY_ROB
`define N_ENTRY_ROB 8
`endif

package free_list_pkg;

  localparam int ARCH_REGS = 32;
  localparam int N_ROB     = `N_ENTRY_ROB;
  // One extra tag beyond ROB + architectural state keeps r0's mapping out of the pool.
  localparam int N_PHYS    = N_ROB + ARCH_REGS + 1;
  localparam int TAG_W     = $clog2(N_PHYS);
  localparam int DEPTH     = N_PHYS - ARCH_REGS;
  localparam int PTR_W     = $clog2(DEPTH);

  typedef logic [TAG_W-1:0] phys_tag_t;

  // Number of asserted bits in a 2-wide slot group.
  function automatic logic [1:0] count2(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/free_list_if.sv
// Dispatch-side allocation, retire-side release and squash signals of the free list.
interface free_list_if;
  import free_list_pkg::*;

  logic             alloc_req_0;
  logic             alloc_req_1;
  phys_tag_t        alloc_tag_0;
  phys_tag_t        alloc_tag_1;
  logic             alloc_gnt_0;
  logic             alloc_gnt_1;
  logic [PTR_W:0]   free_count;
  logic             retire_valid_0;
  logic             retire_valid_1;
  phys_tag_t        Told_in_0;
  phys_tag_t        Told_in_1;
  logic             squash;

  // Rename/retire side driving the list.
  modport master (
    output alloc_req_0, alloc_req_1, retire_valid_0, retire_valid_1,
    output Told_in_0, Told_in_1, squash,
    input  alloc_tag_0, alloc_tag_1, alloc_gnt_0, alloc_gnt_1, free_count
  );

  // The free list itself.
  modport slave (
    input  alloc_req_0, alloc_req_1, retire_valid_0, retire_valid_1,
    input  Told_in_0, Told_in_1, squash,
    output alloc_tag_0, alloc_tag_1, alloc_gnt_0, alloc_gnt_1, free_count
  );
endinterface

// File: rtl/fl_ptr_inc.sv
// Modular pointer increment by 0, 1 or 2 for a ring whose size need not be a power of 2.
module fl_ptr_inc #(
  parameter int DEPTH = 9,
  parameter int PTR_W = 4
) (
  input  logic [PTR_W-1:0] ptr,
  input  logic [1:0]       inc,
  output logic [PTR_W-1:0] ptr_next
);

  logic [PTR_W+1:0] sum;

  // Two spare bits hold ptr+2 without overflow; one conditional subtract wraps it.
  always_comb begin
    sum = {2'b00, ptr} + {{PTR_W{1'b0}}, inc};
    if (sum >= (PTR_W+2)'(DEPTH)) begin
      sum = sum - (PTR_W+2)'(DEPTH);
    end
    ptr_next = sum[PTR_W-1:0];
  end

endmodule

// File: rtl/free_list.sv
// 2-wide circular free list of physical tags. Rename pops from head, retire pushes
// superseded tags at tail, and arch_head tracks the committed head so a squash
// rewinds all speculative allocations in a single cycle.
module free_list #(
  parameter int N_ROB  = free_list_pkg::N_ROB,
  parameter int N_PHYS = N_ROB + 33,
  parameter int TAG_W  = $clog2(N_PHYS),
  parameter int DEPTH  = N_PHYS - 32,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  free_list_if.slave  fl
);
  import free_list_pkg::*;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  tag_t entry_q [DEPTH];
  tag_t entry_d [DEPTH];
  tag_t init_tag [DEPTH];

  ptr_t head_q, head_d;
  ptr_t arch_head_q, arch_head_d;
  ptr_t tail_q, tail_d;
  cnt_t count_q, count_d;

  ptr_t head_p1, tail_p1;
  ptr_t head_adv, arch_adv, tail_adv;
  ptr_t wr_ptr_1;

  logic       gnt_0, gnt_1;
  logic [1:0] n_gnt, n_rel;

  // After reset the list holds every tag not backing an architectural register.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_init
      assign init_tag[gi] = tag_t'(ARCH_REGS + gi);
    end
  endgenerate

  fl_ptr_inc #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_head_p1 (
    .ptr(head_q), .inc(2'd1), .ptr_next(head_p1)
  );
  fl_ptr_inc #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tail_p1 (
    .ptr(tail_q), .inc(2'd1), .ptr_next(tail_p1)
  );
  fl_ptr_inc #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_head_adv (
    .ptr(head_q), .inc(n_gnt), .ptr_next(head_adv)
  );
  fl_ptr_inc #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_arch_adv (
    .ptr(arch_head_q), .inc(n_rel), .ptr_next(arch_adv)
  );
  fl_ptr_inc #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tail_adv (
    .ptr(tail_q), .inc(n_rel), .ptr_next(tail_adv)
  );

  // Grants look only at the registered count, so a same-cycle release never feeds allocation.
  always_comb begin
    gnt_0 = fl.alloc_req_0 && (count_q >= cnt_t'(1)) && !fl.squash && !reset;
    gnt_1 = fl.alloc_req_1 && !fl.squash && !reset &&
            (count_q >= (fl.alloc_req_0 ? cnt_t'(2) : cnt_t'(1)));
    n_gnt = count2(gnt_0, gnt_1);
    n_rel = count2(fl.retire_valid_0, fl.retire_valid_1);
  end

  assign fl.alloc_gnt_0 = gnt_0;
  assign fl.alloc_gnt_1 = gnt_1;
  // Slot 1 takes the next tag only when slot 0 is also consuming one.
  assign fl.alloc_tag_0 = entry_q[head_q];
  assign fl.alloc_tag_1 = fl.alloc_req_0 ? entry_q[head_p1] : entry_q[head_q];
  assign fl.free_count  = count_q;

  // Retired tags are packed at tail in slot order; a lone slot 1 lands at tail itself.
  always_comb begin
    wr_ptr_1 = fl.retire_valid_0 ? tail_p1 : tail_q;
    entry_d  = entry_q;
    if (fl.retire_valid_0) begin
      entry_d[tail_q] = fl.Told_in_0;
    end
    if (fl.retire_valid_1) begin
      entry_d[wr_ptr_1] = fl.Told_in_1;
    end
  end

  // Retire always commits; a squash then rewinds head onto the freshly updated arch_head.
  always_comb begin
    arch_head_d = arch_adv;
    tail_d      = tail_adv;
    if (fl.squash) begin
      head_d  = arch_head_d;
      count_d = cnt_t'(DEPTH);
    end else begin
      head_d  = head_adv;
      count_d = count_q - cnt_t'(n_gnt) + cnt_t'(n_rel);
    end
  end

  // State registers; reset overrides every other update.
  always_ff @(posedge clock) begin
    if (reset) begin
      entry_q     <= init_tag;
      head_q      <= '0;
      arch_head_q <= '0;
      tail_q      <= '0;
      count_q     <= cnt_t'(DEPTH);
    end else begin
      entry_q     <= entry_d;
      head_q      <= head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  // Releasing more tags than the list can hold means the retire side is broken.
  overflow_chk: assert property (@(posedge clock) disable iff (reset)
    ({1'b0, count_q} + {{PTR_W{1'b0}}, n_rel}) <= (PTR_W+2)'(DEPTH));

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: the driver queues hand-computed expectations,
// and an independent monitor checks the DUT outputs every falling edge.
module tb_free_list;
  import free_list_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  free_list_if fl();

  free_list dut (
    .clock (clock),
    .reset (reset),
    .fl    (fl)
  );

  typedef struct {
    string name;
    logic  g0;
    logic  g1;
    int    tag0;
    int    tag1;
    int    cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // One cycle of stimulus plus the outputs expected during that cycle.
  task automatic cyc(input string name, input logic rst, input logic r0, input logic r1,
                     input logic v0, input logic v1, input int t0, input int t1,
                     input logic sq, input logic g0, input logic g1,
                     input int tag0, input int tag1, input int cnt);
    exp_t e;
    @(posedge clock);
    #1;
    reset             = rst;
    fl.alloc_req_0    = r0;
    fl.alloc_req_1    = r1;
    fl.retire_valid_0 = v0;
    fl.retire_valid_1 = v1;
    fl.Told_in_0      = phys_tag_t'(t0);
    fl.Told_in_1      = phys_tag_t'(t1);
    fl.squash         = sq;
    e.name = name; e.g0 = g0; e.g1 = g1; e.tag0 = tag0; e.tag1 = tag1; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per cycle and compares at the falling edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.name, ".gnt0"}, int'(fl.alloc_gnt_0), int'(e.g0));
        chk({e.name, ".gnt1"}, int'(fl.alloc_gnt_1), int'(e.g1));
        if (e.g0) chk({e.name, ".tag0"}, int'(fl.alloc_tag_0), e.tag0);
        if (e.g1) chk({e.name, ".tag1"}, int'(fl.alloc_tag_1), e.tag1);
        if (e.cnt >= 0) chk({e.name, ".count"}, int'(fl.free_count), e.cnt);
        $display("txn %s gnt=%b%b tag0=%0d tag1=%0d count=%0d", e.name,
                 fl.alloc_gnt_0, fl.alloc_gnt_1, fl.alloc_tag_0, fl.alloc_tag_1,
                 fl.free_count);
      end
    end
  end

  initial begin : driver
    int tag;
    logic use_r1, even;
    fl.alloc_req_0 = 1'b0; fl.alloc_req_1 = 1'b0;
    fl.retire_valid_0 = 1'b0; fl.retire_valid_1 = 1'b0;
    fl.Told_in_0 = '0; fl.Told_in_1 = '0; fl.squash = 1'b0;

    // Reset holds off grants even with requests, retires and squash present.
    //   name        rst r0 r1 v0 v1 t0 t1 sq  g0 g1 tag0 tag1 cnt
    cyc("rst_a",     1, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0,  0,  9);
    cyc("rst_b",     1, 1, 1, 1, 1, 5, 6, 1,  0, 0, 0,  0,  9);
    // Two-wide allocation and drain down to the count==1 boundary.
    cyc("pair0",     0, 1, 1, 0, 0, 0, 0, 0,  1, 1, 32, 33, 9);
    cyc("pair1",     0, 1, 1, 0, 0, 0, 0, 0,  1, 1, 34, 35, 7);
    cyc("drain2",    0, 1, 1, 0, 0, 0, 0, 0,  1, 1, 36, 37, 5);
    cyc("drain3",    0, 1, 1, 0, 0, 0, 0, 0,  1, 1, 38, 39, 3);
    cyc("last1",     0, 1, 1, 0, 0, 0, 0, 0,  1, 0, 40, 0,  1);
    cyc("empty",     0, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0,  0,  0);
    // Releases in the same cycle are invisible to allocation.
    cyc("ret57",     0, 1, 1, 1, 1, 5, 7, 0,  0, 0, 0,  0,  0);
    cyc("get57",     0, 1, 1, 0, 0, 0, 0, 0,  1, 1, 5,  7,  2);
    cyc("zero",      0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0,  0);
    // Slot 1 alone takes the head tag.
    cyc("rst_c",     1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0,  0);
    cyc("r1only",    0, 0, 1, 0, 0, 0, 0, 0,  0, 1, 0,  32, 9);
    cyc("r0after",   0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 33, 0,  8);
    // Squash with a same-cycle retire rewinds to the committed head.
    cyc("rst_d",     1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0,  7);
    cyc("sq_a0",     0, 1, 1, 0, 0, 0, 0, 0,  1, 1, 32, 33, 9);
    cyc("sq_a1",     0, 1, 1, 0, 0, 0, 0, 0,  1, 1, 34, 35, 7);
    cyc("sq_sq",     0, 1, 1, 1, 0, 3, 0, 1,  0, 0, 0,  0,  5);
    cyc("sq_d0",     0, 1, 1, 0, 0, 0, 0, 0,  1, 1, 33, 34, 9);
    cyc("sq_d1",     0, 1, 1, 0, 0, 0, 0, 0,  1, 1, 35, 36, 7);
    cyc("sq_d2",     0, 1, 1, 0, 0, 0, 0, 0,  1, 1, 37, 38, 5);
    cyc("sq_d3",     0, 1, 1, 0, 0, 0, 0, 0,  1, 1, 39, 40, 3);
    cyc("sq_d4",     0, 1, 1, 0, 0, 0, 0, 0,  1, 0, 3,  0,  1);
    cyc("sq_e",      0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0,  0);
    // Steady alloc/retire pairs wrap head and tail; tags come back in FIFO order.
    cyc("rst_e",     1, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0,  0,  0);
    cyc("wr_pre",    0, 1, 1, 0, 0, 0, 0, 0,  1, 1, 32, 33, 9);
    for (int k = 0; k < 20; k++) begin
      use_r1 = (k % 3 == 0);
      even   = (k % 2 == 0);
      tag    = (k < 7) ? 34 + k : 3 + k;
      cyc($sformatf("wrap%0d", k), 1'b0, !use_r1, use_r1, even, !even, 10 + k, 10 + k, 1'b0,
          !use_r1, use_r1, tag, tag, 7);
    end
    cyc("wr_end",    0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0,  7);

    @(posedge clock);
    #1;
    fl.alloc_req_0 = 1'b0; fl.alloc_req_1 = 1'b0;
    fl.retire_valid_0 = 1'b0; fl.retire_valid_1 = 1'b0; fl.squash = 1'b0;
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- 2-wide circular free list of physical register tags, on the opposite side of the retire interface from the architectural map table.
- Dispatch/rename pops new tags (Tnew) from the head.
- Retire pushes the superseded tags (Told) onto the tail, in the same cycle the architectural map table consumes Told/Tnew.
- Tracks a committed head pointer so a branch squash restores the list to the committed state in one cycle.

Parameters:
- N_ROB, default `N_ENTRY_ROB: ROB entries.
- N_PHYS, default N_ROB+33: total physical tags.
- TAG_W, default $clog2(N_PHYS): tag width, matching the map tables.
- DEPTH, default N_PHYS-32: free-list entries. Not necessarily a power of 2.
- PTR_W, default $clog2(DEPTH): pointer width.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- alloc_req_0  in  1  dispatch slot 0 needs a new dest tag (dest != r0)
- alloc_req_1  in  1  dispatch slot 1 needs a new dest tag
- alloc_tag_0  out  TAG_W  tag granted to slot 0
- alloc_tag_1  out  TAG_W  tag granted to slot 1
- alloc_gnt_0  out  1  slot 0 request granted this cycle
- alloc_gnt_1  out  1  slot 1 request granted this cycle
- free_count  out  PTR_W+1  registered number of free tags
- retire_valid_0  in  1  retire slot 0 releases a tag
- retire_valid_1  in  1  retire slot 1 releases a tag
- Told_in_0  in  TAG_W  tag freed by retire slot 0
- Told_in_1  in  TAG_W  tag freed by retire slot 1
- squash  in  1  mispredict recovery; discard all speculative allocations

Behaviour:
- Interface: reset is synchronous, active-high; clock is clock. All state updates on posedge clock.
- Storage:
  - entry[DEPTH] of TAG_W.
  - Registers: head (speculative alloc), arch_head (committed alloc), tail (release), count.
- Reset:
  - entry[i]=32+i; head=arch_head=tail=0; count=DEPTH.
  - free_count=DEPTH after reset.
  - During reset, alloc_gnt_*=0 and alloc requests have no effect.
- Pointer increment is modular: ptr+1 wraps to 0 when ptr==DEPTH-1. ptr+2 wraps likewise.
- Grant is combinational from registered count and the current requests. Same-cycle release is never visible to allocation.
  - alloc_gnt_0 = alloc_req_0 && count>=1 && !squash.
  - alloc_gnt_1 = alloc_req_1 && !squash && count>=(alloc_req_0 ? 2 : 1).
  - When count==1 and both request: slot 0 wins, slot 1 is not granted.
- Tag outputs:
  - alloc_tag_0 = entry[head].
  - alloc_tag_1 = alloc_req_0 ? entry[head+1] : entry[head].
  - Tags are always driven; they are meaningful only with the matching gnt.
- Allocation: head advances by the number of grants (0..2). An ungranted request leaves the pointers unchanged.
- Retire:
  - Each valid slot writes Told at the tail in slot order (slot 0 at tail, slot 1 next); tail advances by the number of valid slots.
  - arch_head advances by the same number, because each retired instruction had allocated exactly one tag.
  - retire_valid_1 without retire_valid_0 is legal and writes at tail.
- count_next = count − grants + releases.
- Squash:
  - arch_head and tail first take their retire updates for this cycle.
  - Then head <= arch_head_next and count <= DEPTH.
  - Committed free count is invariantly DEPTH.
  - Grants are forced to 0 in the squash cycle.
- Overflow (count+releases>DEPTH) is illegal; the RTL carries an assertion, not recovery logic.
- Reset mid-operation: reset overrides squash, retire and alloc, and restores the reset state.

Decomposition:
- Shared package holds:
  - TAG_W/N_PHYS/DEPTH derivation from `N_ENTRY_ROB, shared with the architectural and speculative map tables.
  - phys_tag_t typedef.
  - ARCH_REGS=32 constant.
- One sub-module is natural: fl_ptr_inc, a modular +0/+1/+2 pointer incrementer for non-power-of-2 DEPTH, instantiated for head, arch_head and tail.

Test Plan (N_ROB=8 → N_PHYS=41, DEPTH=9, TAG_W=6):
- Reset, then both alloc_req=1 → gnt_0=gnt_1=1, tags 32,33; next cycle free_count=7, tags 34,35.
- Drain to count=1, both request → gnt_0=1 with tag 40, gnt_1=0; next cycle count=0 and all gnt=0.
- alloc_req_1 only, from reset → gnt_1=1, alloc_tag_1=32, gnt_0=0; head=1.
- From the count=0 state: retire Told 5 and 7 with both valid, same cycle as two requests → no grant that cycle; next cycle count=2, tags 5,7.
- Allocate 4 (32..35), retire 1 (Told=3), squash the same cycle → next cycle count=9, alloc_tag_0=33, tail slot holds 3; subsequent drain yields 33..40,3.
- Wrap: cycle 20 alloc/retire pairs → head/tail wrap past 8 to 0, count stays constant, tags are returned FIFO order.
